// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector with saturating match counter (optional SD_PATTERN_LOAD_EN)
module seq_detector_param #(
  parameter int unsigned          PAT_W   = 3,
  parameter logic [PAT_W-1:0]     PATTERN = 3'b101,
  parameter int unsigned          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             cnt_clr,
`ifdef SD_PATTERN_LOAD_EN
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
`endif
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int unsigned        FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PAT_W - 1);

  generate
    if (PAT_W < 2 || PAT_W > 32) begin : g_bad_pat_w
      $error("seq_detector_param: PAT_W must be in 2..32");
    end
  endgenerate

  logic [PAT_W-2:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [CNT_W-1:0]  r_cnt;

  logic [PAT_W-1:0]  w_cand;
  logic [PAT_W-1:0]  w_pat;
  logic              w_load;
  logic              w_accept;
  logic              w_match;

`ifdef SD_PATTERN_LOAD_EN
  logic [PAT_W-1:0]  r_pat;

  // Runtime pattern register; reset restores the elaborated default
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat <= PATTERN;
    end else if (pat_load) begin
      r_pat <= pat_in;
    end
  end

  assign w_pat  = r_pat;
  assign w_load = pat_load;
`else
  assign w_pat  = PATTERN;
  assign w_load = 1'b0;
`endif

  // Newest bit sits in the LSB so the candidate lines up with PATTERN (MSB oldest)
  assign w_cand   = {r_hist, i};
  // A pattern load discards history, so the bit presented alongside it is not accepted
  assign w_accept = in_valid & ~rst & ~w_load;
  assign w_match  = w_accept & (r_fill == FILL_MAX) & (w_cand == w_pat);

  // History shift register and fill count; a non-overlapping match restarts from empty
  always_ff @(posedge clk) begin
    if (rst || w_load) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (in_valid) begin
      if (w_match && !overlap) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_cand[PAT_W-2:0];
        if (r_fill != FILL_MAX) begin
          r_fill <= r_fill + FILL_W'(1);
        end
      end
    end
  end

  // Saturating match counter; clear wins over a simultaneous match
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_cnt <= '0;
    end else if (w_match && !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign match     = w_match;
  assign match_cnt = r_cnt;
  assign cnt_sat   = ~rst & (&r_cnt);

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector. Successor to the fixed 3-bit "101" overlapping Mealy detector.
- Generalised in four ways:
  - pattern width and value are parameters;
  - runtime mode selects overlapping or non-overlapping detection;
  - an input-valid qualifier allows gaps in the serial stream;
  - a saturating match counter is added.
- Sits on a serial bit stream ahead of framing/alignment logic; match is a same-cycle (Mealy) pulse.

Parameters:
- PAT_W, 3, pattern length in bits; legal range 2..32.
- PATTERN, 3'b101, pattern to detect; MSB is the oldest bit and LSB the newest bit received.
- CNT_W, 8, width of match counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- i  in  1  serial data bit.
- in_valid  in  1  i is sampled only when high.
- overlap  in  1  1 = overlapping detection; 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_cnt.
- match  out  1  combinational pulse; high in the cycle the final pattern bit is presented.
- match_cnt  out  CNT_W  number of matches since reset/clear; saturates.
- cnt_sat  out  1  high while match_cnt is all-ones.

Behaviour:
- Reset: synchronous, active-high.
  - Internal state on the rst clock edge: hist <= 0, fill <= 0, match_cnt <= 0.
  - Outputs: cnt_sat = 0 and match = 0 while rst is high.
  - Reset mid-stream discards all partial history.
- State:
  - hist: PAT_W-1 bit shift register of previously accepted bits.
  - fill: count of valid history bits, saturates at PAT_W-1, width clog2(PAT_W).
- Accept: a bit is accepted when in_valid=1 and rst=0. When in_valid=0, hist, fill and match_cnt hold and match=0.
- Candidate word: cand = {hist, i}.
- Match (combinational): match = in_valid & ~rst & (fill == PAT_W-1) & (cand == PATTERN).
  - No match is possible until PAT_W bits have been accepted since reset or since the last clear of history.
- Update on accepted bit, no match: hist <= cand[PAT_W-2:0]; fill <= min(fill+1, PAT_W-1).
- Update on accepted bit with match:
  - overlap=1: shift as normal, so a pattern suffix can start the next match. For 101, stream 10101 gives two matches.
  - overlap=0: hist <= 0, fill <= 0; the next match needs PAT_W fresh bits.
- overlap may change any cycle; the value sampled in the matching cycle governs that update.
- Counter:
  - On match, match_cnt <= match_cnt+1, unless already all-ones (then holds).
  - cnt_clr=1 forces match_cnt <= 0 and has priority over a simultaneous match (result 0).
  - cnt_clr does not affect hist or fill.
- cnt_sat = (match_cnt == {CNT_W{1'b1}}), registered-value derived.
- Latency: match is 0-cycle from the final bit; match_cnt reflects that match on the next clock edge.
- Only the first PAT_W bits of PATTERN are compared.
- Elaboration error if PAT_W < 2 or PAT_W > 32.

Optional Feature:
- Macro: SD_PATTERN_LOAD_EN.
- Defined:
  - Adds ports pat_load (in, 1) and pat_in (in, PAT_W).
  - Pattern register pat_q resets to PATTERN; it loads pat_in on the clock edge when pat_load=1.
  - A load also clears hist and fill; match is forced to 0 in the load cycle.
  - Comparison uses pat_q.
- Undefined: ports absent; comparison uses the PATTERN constant; no pattern register is synthesised.

Test Plan:
1. PATTERN=101, overlap=1, in_valid=1, i=1,0,1,0,1 → match high on bits 3 and 5; match_cnt=2 after last edge.
2. Same stream, overlap=0 → match high on bit 3 only; match_cnt=1.
3. overlap=1, bits 1,0 with in_valid high, then 3 cycles in_valid=0 (i toggling), then bit 1 with in_valid high → match=0 during gap; match=1 on final valid bit.
4. Bits 1,0, then rst=1 for one cycle, then bit 1 → match=0; match_cnt=0. Then continue 0,1 → match on the 5th accepted... exactly on the 3rd post-reset bit.
5. CNT_W=2, overlap=1, stream 1010101010 (4 matches) → match_cnt=3, cnt_sat=1 after 3rd match, holds at 3 after 4th. Then assert cnt_clr in the same cycle as a match → match_cnt=0, cnt_sat=0.
6. SD_PATTERN_LOAD_EN, PAT_W=4: load pat_in=4'b1100 after bits 1,1 → no match in load cycle. Stream 1,1,0,0 → match on 4th bit; old pattern bits 0,1,0,1 are no longer detected.
